// File: rtl/rtc_init_sequencer.sv
// Power-up sequencer for the RTC multiplexed AD bus: writes a table of {addr,data}
// pairs with programmable phase timing, then optionally reads them back and verifies.
module rtc_init_sequencer #(
    parameter int DW        = 8,
    parameter int N_ENTRIES = 9,
    parameter int T_PH      = 4,
    parameter int VERIFY    = 1,
    parameter logic [N_ENTRIES*2*DW-1:0] INIT_TABLE = '0,
    localparam int EW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1,
    localparam int PW = $clog2(T_PH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] ad_in,
    output logic [DW-1:0] ad_out,
    output logic          ad_oe,
    output logic          cs_n,
    output logic          rd_n,
    output logic          wr_n,
    output logic          a_d,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [EW-1:0] err_idx,
    output logic [EW-1:0] entry
);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] W_ADR  = 4'd1;
    localparam logic [3:0] W_GAP1 = 4'd2;
    localparam logic [3:0] W_DAT  = 4'd3;
    localparam logic [3:0] W_GAP2 = 4'd4;
    localparam logic [3:0] R_ADR  = 4'd5;
    localparam logic [3:0] R_GAP1 = 4'd6;
    localparam logic [3:0] R_DAT  = 4'd7;
    localparam logic [3:0] R_GAP2 = 4'd8;
    localparam logic [3:0] DONE   = 4'd9;

    logic [3:0]    state;
    logic [PW-1:0] phase;
    logic          phase_last;
    logic          last_entry;

    logic [DW-1:0] addr_tab [N_ENTRIES];
    logic [DW-1:0] data_tab [N_ENTRIES];

    for (genvar i = 0; i < N_ENTRIES; i++) begin : g_tab
        assign addr_tab[i] = INIT_TABLE[(2*i+1)*DW +: DW];
        assign data_tab[i] = INIT_TABLE[(2*i)*DW +: DW];
    end

    assign phase_last = (phase == PW'(T_PH - 1));
    assign last_entry = (entry == EW'(N_ENTRIES - 1));

    // Every active state runs T_PH cycles; the phase counter restarts on each transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= '0;
            entry   <= '0;
            err     <= 1'b0;
            err_idx <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= W_ADR;
                        phase   <= '0;
                        entry   <= '0;
                        err     <= 1'b0;
                        err_idx <= '0;
                    end
                end
                default: begin
                    if (!phase_last) begin
                        phase <= phase + 1'b1;
                    end else begin
                        phase <= '0;
                        case (state)
                            W_ADR:  state <= W_GAP1;
                            W_GAP1: state <= W_DAT;
                            W_DAT:  state <= W_GAP2;
                            W_GAP2: begin
                                if (!last_entry) begin
                                    entry <= entry + 1'b1;
                                    state <= W_ADR;
                                end else if (VERIFY != 0) begin
                                    entry <= '0;
                                    state <= R_ADR;
                                end else begin
                                    state <= DONE;
                                end
                            end
                            R_ADR:  state <= R_GAP1;
                            R_GAP1: state <= R_DAT;
                            R_DAT: begin
                                state <= R_GAP2;
                                // Only the first mismatch is recorded.
                                if ((ad_in != data_tab[entry]) && !err) begin
                                    err     <= 1'b1;
                                    err_idx <= entry;
                                end
                            end
                            R_GAP2: begin
                                if (!last_entry) begin
                                    entry <= entry + 1'b1;
                                    state <= R_ADR;
                                end else begin
                                    state <= DONE;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // Bus pins decode straight from state so a reset edge drops every strobe at once.
    always_comb begin
        ad_out = '0;
        ad_oe  = 1'b0;
        cs_n   = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        a_d    = 1'b0;
        case (state)
            W_ADR, R_ADR: begin
                cs_n   = 1'b0;
                wr_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr_tab[entry];
            end
            W_DAT: begin
                cs_n   = 1'b0;
                wr_n   = 1'b0;
                a_d    = 1'b1;
                ad_oe  = 1'b1;
                ad_out = data_tab[entry];
            end
            R_DAT: begin
                cs_n = 1'b0;
                rd_n = 1'b0;
                a_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_rtc_init_sequencer.sv
// Bench for rtc_init_sequencer: three instances (verify, write-only, single-entry)
// checked cycle by cycle against a waveform derived from the phase/entry arithmetic.
module tb_rtc_init_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_v, start_w, start_s;
    int   sel;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] v_ad_in, v_ad_out, w_ad_in, w_ad_out, s_ad_in, s_ad_out;
    logic v_oe, v_cs, v_rd, v_wr, v_ad, v_busy, v_done, v_err;
    logic w_oe, w_cs, w_rd, w_wr, w_ad, w_busy, w_done, w_err;
    logic s_oe, s_cs, s_rd, s_wr, s_ad, s_busy, s_done, s_err;
    logic [1:0] v_idx, v_entry, w_idx, w_entry;
    logic [0:0] s_idx, s_entry;

    rtc_init_sequencer #(.DW(8), .N_ENTRIES(3), .T_PH(2), .VERIFY(1),
                         .INIT_TABLE(48'h10D2_2100_0210)) dut_v (
        .clk(clk), .reset(reset), .start(start_v), .ad_in(v_ad_in), .ad_out(v_ad_out),
        .ad_oe(v_oe), .cs_n(v_cs), .rd_n(v_rd), .wr_n(v_wr), .a_d(v_ad), .busy(v_busy),
        .done(v_done), .err(v_err), .err_idx(v_idx), .entry(v_entry));

    rtc_init_sequencer #(.DW(8), .N_ENTRIES(3), .T_PH(2), .VERIFY(0),
                         .INIT_TABLE(48'h10D2_2100_0210)) dut_w (
        .clk(clk), .reset(reset), .start(start_w), .ad_in(w_ad_in), .ad_out(w_ad_out),
        .ad_oe(w_oe), .cs_n(w_cs), .rd_n(w_rd), .wr_n(w_wr), .a_d(w_ad), .busy(w_busy),
        .done(w_done), .err(w_err), .err_idx(w_idx), .entry(w_entry));

    rtc_init_sequencer #(.DW(8), .N_ENTRIES(1), .T_PH(1), .VERIFY(1),
                         .INIT_TABLE(16'h5AC3)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .ad_in(s_ad_in), .ad_out(s_ad_out),
        .ad_oe(s_oe), .cs_n(s_cs), .rd_n(s_rd), .wr_n(s_wr), .a_d(s_ad), .busy(s_busy),
        .done(s_done), .err(s_err), .err_idx(s_idx), .entry(s_entry));

    // RTC device model: latches address on address-phase writes, stores data-phase writes,
    // and answers reads from its memory with an optional per-address corruption mask.
    logic [7:0] mem     [256];
    logic [7:0] corrupt [256];
    logic [7:0] lat = 8'h00;
    logic [7:0] corrupt_s;

    always @(posedge clk) begin
        if (!v_cs && !v_wr) begin
            if (!v_ad) lat <= v_ad_out;
            else       mem[lat] <= v_ad_out;
        end
    end

    assign v_ad_in = mem[lat] ^ corrupt[lat];
    assign w_ad_in = 8'h00;
    assign s_ad_in = 8'hC3 ^ corrupt_s;

    logic [7:0] o_out;
    logic o_oe, o_cs, o_rd, o_wr, o_ad, o_busy, o_done, o_err;
    logic [3:0] o_idx, o_entry;

    always_comb begin
        o_out = v_ad_out; o_oe = v_oe; o_cs = v_cs; o_rd = v_rd; o_wr = v_wr; o_ad = v_ad;
        o_busy = v_busy; o_done = v_done; o_err = v_err;
        o_idx = {2'b00, v_idx}; o_entry = {2'b00, v_entry};
        if (sel == 1) begin
            o_out = w_ad_out; o_oe = w_oe; o_cs = w_cs; o_rd = w_rd; o_wr = w_wr; o_ad = w_ad;
            o_busy = w_busy; o_done = w_done; o_err = w_err;
            o_idx = {2'b00, w_idx}; o_entry = {2'b00, w_entry};
        end else if (sel == 2) begin
            o_out = s_ad_out; o_oe = s_oe; o_cs = s_cs; o_rd = s_rd; o_wr = s_wr; o_ad = s_ad;
            o_busy = s_busy; o_done = s_done; o_err = s_err;
            o_idx = {3'b000, s_idx}; o_entry = {3'b000, s_entry};
        end
    end

    function automatic logic [7:0] tabAddr(input int s, input int e);
        logic [7:0] a3 [3];
        a3 = '{8'h02, 8'h21, 8'h10};
        return (s == 2) ? 8'h5A : a3[e];
    endfunction

    function automatic logic [7:0] tabData(input int s, input int e);
        logic [7:0] d3 [3];
        d3 = '{8'h10, 8'h00, 8'hD2};
        return (s == 2) ? 8'hC3 : d3[e];
    endfunction

    function automatic logic [31:0] pack(input logic oe, cs, rd, wr, ad, input logic [7:0] out,
                                         input logic bsy, dn, er, input logic [3:0] idx, ent);
        return {8'h00, oe, cs, rd, wr, ad, out, bsy, dn, er, idx, ent};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setStart(input int s, input logic v);
        case (s)
            0: start_v = v;
            1: start_w = v;
            default: start_s = v;
        endcase
    endtask

    task automatic checkIdle(input string tag);
        checkOutput(tag, pack(o_oe, o_cs, o_rd, o_wr, o_ad, o_out, o_busy, o_done, o_err,
                              o_idx, o_entry),
                    pack(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0));
    endtask

    // One start-to-done run. glitch_at pulses start while busy; abort_at applies reset
    // (together with start) after that cycle's check and ends the run.
    task automatic applyStimulus(input int s, input int n, input int t, input bit ver,
                                 input int glitch_at, input int abort_at);
        int L, bad_e, p, k, e, err_at;
        logic oe, cs, rd, wr, ad, er;
        logic [7:0] out;
        logic [3:0] idx;
        L = 4 * t * n * (ver ? 2 : 1);
        bad_e = -1;
        if (ver) begin
            for (int i = n - 1; i >= 0; i--) begin
                if (s == 0 && corrupt[tabAddr(s, i)] != 8'h00) bad_e = i;
                if (s == 2 && corrupt_s != 8'h00) bad_e = i;
            end
        end
        err_at = (bad_e >= 0) ? (4 * n + 4 * bad_e + 3) * t : L + 1;
        sel = s;
        @(negedge clk);
        setStart(s, 1'b1);
        @(negedge clk);
        setStart(s, 1'b0);
        for (int c = 0; c < L; c++) begin
            if (c > 0) @(negedge clk);
            setStart(s, (c == glitch_at) ? 1'b1 : 1'b0);
            p = c / t; k = p % 4; e = (p / 4) % n;
            oe = 1'b0; cs = 1'b1; rd = 1'b1; wr = 1'b1; ad = 1'b0; out = 8'h00;
            if (k == 0) begin
                oe = 1'b1; cs = 1'b0; wr = 1'b0; out = tabAddr(s, e);
            end else if (k == 2 && p < 4 * n) begin
                oe = 1'b1; cs = 1'b0; wr = 1'b0; ad = 1'b1; out = tabData(s, e);
            end else if (k == 2) begin
                cs = 1'b0; rd = 1'b0; ad = 1'b1;
            end
            er  = (c >= err_at);
            idx = er ? 4'(bad_e) : 4'd0;
            checkOutput($sformatf("run%0d_c%0d", s, c),
                        pack(o_oe, o_cs, o_rd, o_wr, o_ad, o_oe ? o_out : 8'h00, o_busy, o_done,
                             o_err, o_idx, o_entry),
                        pack(oe, cs, rd, wr, ad, out, 1'b1, 1'b0, er, idx, 4'(e)));
            if (c == abort_at) begin
                reset = 1'b1;
                setStart(s, 1'b1);
                @(negedge clk);
                reset = 1'b0;
                setStart(s, 1'b0);
                checkIdle($sformatf("abort%0d", s));
                return;
            end
        end
        @(negedge clk);
        setStart(s, 1'b0);
        checkOutput($sformatf("done%0d", s),
                    pack(o_oe, o_cs, o_rd, o_wr, o_ad, o_out, o_busy, o_done, o_err, o_idx, o_entry),
                    pack(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, bad_e >= 0,
                         (bad_e >= 0) ? 4'(bad_e) : 4'd0, 4'(n - 1)));
    endtask

    // Directed scenarios first, then randomized corruption and start-while-busy timing.
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            corrupt[i] = 8'h00;
        end
        corrupt_s = 8'h00;
        sel = 0;
        reset = 1'b1;
        start_v = 1'b0; start_w = 1'b0; start_s = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkIdle($sformatf("reset%0d", s));
        end
        reset = 1'b0;

        $display("[TB] write-only, N=3 T_PH=2");
        applyStimulus(1, 3, 2, 1'b0, -1, -1);

        $display("[TB] verify with echoing RTC");
        applyStimulus(0, 3, 2, 1'b1, -1, -1);

        $display("[TB] verify with corrupted read-back");
        corrupt[8'h10] = 8'h01;
        corrupt[8'h21] = 8'h01;
        applyStimulus(0, 3, 2, 1'b1, -1, -1);
        corrupt[8'h10] = 8'h00;
        corrupt[8'h21] = 8'h00;

        $display("[TB] reset during W_DAT of entry 1, then rerun");
        applyStimulus(0, 3, 2, 1'b1, -1, 12);
        applyStimulus(0, 3, 2, 1'b1, -1, -1);

        $display("[TB] start while busy, then restart from DONE");
        applyStimulus(0, 3, 2, 1'b1, 5, -1);
        applyStimulus(0, 3, 2, 1'b1, 40, -1);

        $display("[TB] single entry, T_PH=1");
        applyStimulus(2, 1, 1, 1'b1, -1, -1);
        corrupt_s = 8'(1 << $urandom_range(0, 7));
        applyStimulus(2, 1, 1, 1'b1, 3, -1);
        corrupt_s = 8'h00;

        $display("[TB] randomized read-back corruption");
        for (int r = 0; r < 6; r++) begin
            for (int e = 0; e < 3; e++)
                corrupt[tabAddr(0, e)] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(0, 3, 2, 1'b1, int'($urandom_range(0, 46)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
